mistral_lut_cfg_loader: RTL and testbench

- Runtime configuration controller for a bank of NUM_LUTS reconfigurable 4-input LUTs.
- Accepts commands over a valid/ready interface, receives 16-bit LUT masks bit-serially into a shadow register, and commits each mask atomically into the live bank.
- Supports serial readback of live masks and a clear-all operation.
- Evaluates every LUT combinationally from its live mask, using the standard Mistral LUT4 index ordering. Sits between a config host (JTAG/CSR bridge) and soft logic that needs field-updatable truth tables.

---
 rtl/mistral_cfg_pkg.sv | 22 ++
 rtl/mistral_lut4_eval.sv | 32 +++
 rtl/mistral_lut_cfg_loader.sv | 146 ++++++++++++++
 tb/tb_mistral_lut_cfg_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mistral_cfg_pkg.sv
// Shared types and constants for the Mistral LUT4 configuration loader.
package mistral_cfg_pkg;

   localparam int unsigned MASK_W = 16;
   localparam int unsigned LUT_K  = 4;

   typedef enum logic [1:0] {
      OP_LOAD      = 2'b00,
      OP_READBACK  = 2'b01,
      OP_CLEAR_ALL = 2'b10,
      OP_ILLEGAL   = 2'b11
   } cfg_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COMMIT,
      ST_READ,
      ST_CLEAR
   } cfg_state_e;

endpackage

// File: rtl/mistral_lut4_eval.sv
// Combinational LUT4: selects one mask bit by {D,C,B,A}, A being the LSB.
module mistral_lut4_eval
   import mistral_cfg_pkg::*;
(
   input  logic [MASK_W-1:0] mask,
   input  logic              a,
   input  logic              b,
   input  logic              c,
   input  logic              d,
   output logic              q
);

   logic [7:0] s_a;
   logic [3:0] s_b;
   logic [1:0] s_c;

   // Mux tree in cell order: A picks between adjacent mask bits, D is the final select.
   for (genvar i = 0; i < 8; i++) begin : g_sel_a
      assign s_a[i] = a ? mask[2*i+1] : mask[2*i];
   end

   for (genvar i = 0; i < 4; i++) begin : g_sel_b
      assign s_b[i] = b ? s_a[2*i+1] : s_a[2*i];
   end

   for (genvar i = 0; i < 2; i++) begin : g_sel_c
      assign s_c[i] = c ? s_b[2*i+1] : s_b[2*i];
   end

   assign q = d ? s_c[1] : s_c[0];

endmodule

// File: rtl/mistral_lut_cfg_loader.sv
// Runtime loader for a bank of LUT4 masks: serial load into a shadow register,
// atomic commit into the live bank, serial readback and clear-all.
module mistral_lut_cfg_loader
   import mistral_cfg_pkg::*;
#(
   parameter int unsigned       NUM_LUTS  = 4,
   parameter int unsigned       ADDR_W    = 2,
   parameter logic [MASK_W-1:0] INIT_MASK = 16'h0000
) (
   input  logic                      CLK,
   input  logic                      ACLR,
   input  logic                      CMD_VALID,
   output logic                      CMD_READY,
   input  logic [1:0]                CMD_OP,
   input  logic [ADDR_W-1:0]         CMD_ADDR,
   input  logic                      SDI,
   input  logic                      SDI_VALID,
   output logic                      SDO,
   output logic                      SDO_VALID,
   output logic                      DONE,
   output logic                      ERR,
   input  logic [LUT_K*NUM_LUTS-1:0] LUT_IN,
   output logic [NUM_LUTS-1:0]       LUT_OUT
);

   cfg_state_e        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [MASK_W-1:0] shadow_q, shadow_d;
   logic [MASK_W-1:0] live_q [NUM_LUTS];
   logic [MASK_W-1:0] live_d [NUM_LUTS];
   logic              done_q, done_d;
   logic              err_q, err_d;

   cfg_op_e           op;
   logic              addr_bad;

   assign op       = cfg_op_e'(CMD_OP);
   assign addr_bad = (32'(CMD_ADDR) >= NUM_LUTS);

   // Next-state, datapath updates and handshake/serial outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      shadow_d  = shadow_q;
      live_d    = live_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      CMD_READY = (state_q == ST_IDLE);
      SDO       = 1'b0;
      SDO_VALID = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (CMD_VALID) begin
               if (op == OP_ILLEGAL || addr_bad) begin
                  err_d = 1'b1;
               end else begin
                  addr_d = CMD_ADDR;
                  cnt_d  = '0;
                  unique case (op)
                     OP_LOAD:      state_d = ST_LOAD;
                     OP_READBACK:  state_d = ST_READ;
                     OP_CLEAR_ALL: state_d = ST_CLEAR;
                     default:      state_d = ST_IDLE;
                  endcase
               end
            end
         end

         ST_LOAD: begin
            if (SDI_VALID) begin
               shadow_d[cnt_q] = SDI;
               cnt_d           = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_d = ST_COMMIT;
               end
            end
         end

         ST_COMMIT: begin
            live_d[addr_q] = shadow_q;
            done_d         = 1'b1;
            state_d        = ST_IDLE;
         end

         ST_READ: begin
            SDO_VALID = 1'b1;
            SDO       = live_q[addr_q][cnt_q];
            cnt_d     = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end

         ST_CLEAR: begin
            live_d  = '{default: INIT_MASK};
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and datapath registers; clear aborts any operation in flight.
   always_ff @(posedge CLK or negedge ACLR) begin
      if (!ACLR) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         shadow_q <= '0;
         live_q   <= '{default: INIT_MASK};
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         shadow_q <= shadow_d;
         live_q   <= live_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign DONE = done_q;
   assign ERR  = err_q;

   for (genvar g = 0; g < NUM_LUTS; g++) begin : g_lut
      mistral_lut4_eval u_eval (
         .mask (live_q[g]),
         .a    (LUT_IN[LUT_K*g + 0]),
         .b    (LUT_IN[LUT_K*g + 1]),
         .c    (LUT_IN[LUT_K*g + 2]),
         .d    (LUT_IN[LUT_K*g + 3]),
         .q    (LUT_OUT[g])
      );
   end

endmodule

// File: tb/tb_mistral_lut_cfg_loader.sv
// Randomized self-checking bench for mistral_lut_cfg_loader with three LUT slots.
module tb_mistral_lut_cfg_loader;

   localparam int NL = 3;

   logic            CLK;
   logic            ACLR;
   logic            CMD_VALID;
   logic            CMD_READY;
   logic [1:0]      CMD_OP;
   logic [1:0]      CMD_ADDR;
   logic            SDI;
   logic            SDI_VALID;
   logic            SDO;
   logic            SDO_VALID;
   logic            DONE;
   logic            ERR;
   logic [4*NL-1:0] LUT_IN;
   logic [NL-1:0]   LUT_OUT;

   int checks = 0;
   int errors = 0;

   logic [15:0] model_mask [NL];

   mistral_lut_cfg_loader #(
      .NUM_LUTS  (NL),
      .ADDR_W    (2),
      .INIT_MASK (16'h0000)
   ) dut (
      .CLK       (CLK),
      .ACLR      (ACLR),
      .CMD_VALID (CMD_VALID),
      .CMD_READY (CMD_READY),
      .CMD_OP    (CMD_OP),
      .CMD_ADDR  (CMD_ADDR),
      .SDI       (SDI),
      .SDI_VALID (SDI_VALID),
      .SDO       (SDO),
      .SDO_VALID (SDO_VALID),
      .DONE      (DONE),
      .ERR       (ERR),
      .LUT_IN    (LUT_IN),
      .LUT_OUT   (LUT_OUT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // Truth-table semantics: input index is D*8 + C*4 + B*2 + A.
   function automatic logic [NL-1:0] model_out(input logic [4*NL-1:0] in);
      logic [NL-1:0] r;
      int            idx;
      r = '0;
      for (int i = 0; i < NL; i++) begin
         idx = 8 * int'(in[4*i+3]) + 4 * int'(in[4*i+2]) + 2 * int'(in[4*i+1]) + int'(in[4*i]);
         r[i] = model_mask[i][idx[3:0]];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < NL; i++) model_mask[i] = 16'h0000;
   endtask

   task automatic issue(input logic [1:0] op, input logic [1:0] addr, input string name);
      CMD_VALID = 1'b1;
      CMD_OP    = op;
      CMD_ADDR  = addr;
      #1;
      checks++;
      if (CMD_READY !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready act=%b exp=1", name, CMD_READY);
      end
      tick();
      CMD_VALID = 1'b0;
   endtask

   // Exhaustive LUT input sweep against the model while idle.
   task automatic sweep(input string name);
      for (int v = 0; v < 16; v++) begin
         tick();
         LUT_IN = {NL{4'(v)}};
         #1;
         checks++;
         if (LUT_OUT !== model_out(LUT_IN) || DONE !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL %s_sweep v=%0d act=%b/%b/%b exp=%b/0/0", name, v, LUT_OUT, DONE, ERR,
                     model_out(LUT_IN));
         end
      end
   endtask

   // mode 0: continuous SDI_VALID, 1: every other cycle, 2: random stalls.
   task automatic run_load(input logic [1:0] addr, input logic [15:0] mask, input int mode,
                           input string name);
      int k        = 0;
      int exp_done = -1;
      bit seen     = 1'b0;
      bit present;
      issue(2'b00, addr, name);
      for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
         LUT_IN = (4*NL)'($urandom);
         if (k >= 16) begin
            CMD_VALID = 1'b0;
            SDI       = 1'($urandom);
            SDI_VALID = 1'($urandom);
         end else begin
            CMD_VALID = 1'($urandom);
            CMD_OP    = 2'($urandom);
            CMD_ADDR  = 2'($urandom);
            present   = (mode == 0) || (mode == 1 && (cyc % 2) == 0) ||
                        (mode == 2 && $urandom_range(0, 3) != 0);
            SDI_VALID = present;
            SDI       = present ? mask[k] : 1'($urandom);
            if (present) begin
               k++;
               if (k == 16) exp_done = cyc + 2;
            end
         end
         #1;
         if (DONE === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (cyc != exp_done) begin
               errors++;
               $display("FAIL %s_done_cycle act=%0d exp=%0d", name, cyc, exp_done);
            end
            model_mask[addr] = mask;
            checks++;
            if (LUT_OUT !== model_out(LUT_IN) || ERR !== 1'b0 || CMD_READY !== 1'b1) begin
               errors++;
               $display("FAIL %s_commit act=%b/%b/%b exp=%b/0/1", name, LUT_OUT, ERR, CMD_READY,
                        model_out(LUT_IN));
            end
         end else begin
            checks++;
            if (LUT_OUT !== model_out(LUT_IN) || CMD_READY !== 1'b0 || ERR !== 1'b0) begin
               errors++;
               $display("FAIL %s_busy cyc=%0d act=%b/%b/%b exp=%b/0/0", name, cyc, LUT_OUT,
                        CMD_READY, ERR, model_out(LUT_IN));
            end
         end
         if (!seen) tick();
      end
      CMD_VALID = 1'b0;
      SDI_VALID = 1'b0;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout act=no_done exp=done_at_%0d", name, exp_done);
      end
   endtask

   task automatic run_readback(input logic [1:0] addr, input string name);
      logic [3:0] b;
      issue(2'b01, addr, name);
      for (int cyc = 1; cyc <= 16; cyc++) begin
         b         = 4'(cyc - 1);
         SDI_VALID = 1'($urandom);
         SDI       = 1'($urandom);
         LUT_IN    = (4*NL)'($urandom);
         #1;
         checks++;
         if (SDO_VALID !== 1'b1 || SDO !== model_mask[addr][b] || DONE !== 1'b0 ||
             LUT_OUT !== model_out(LUT_IN)) begin
            errors++;
            $display("FAIL %s_bit%0d act=%b/%b/%b exp=1/%b/0", name, b, SDO_VALID, SDO, DONE,
                     model_mask[addr][b]);
         end
         tick();
      end
      SDI_VALID = 1'b0;
      #1;
      checks++;
      if (DONE !== 1'b1 || SDO_VALID !== 1'b0 || CMD_READY !== 1'b1) begin
         errors++;
         $display("FAIL %s_done act=%b/%b/%b exp=1/0/1", name, DONE, SDO_VALID, CMD_READY);
      end
   endtask

   task automatic run_reject(input logic [1:0] op, input logic [1:0] addr, input string name);
      issue(op, addr, name);
      LUT_IN = (4*NL)'($urandom);
      #1;
      checks++;
      if (ERR !== 1'b1 || DONE !== 1'b0 || CMD_READY !== 1'b1) begin
         errors++;
         $display("FAIL %s_err act=%b/%b/%b exp=1/0/1", name, ERR, DONE, CMD_READY);
      end
      tick();
      #1;
      checks++;
      if (ERR !== 1'b0 || LUT_OUT !== model_out(LUT_IN)) begin
         errors++;
         $display("FAIL %s_after act=%b/%b exp=0/%b", name, ERR, LUT_OUT, model_out(LUT_IN));
      end
   endtask

   task automatic test_reset();
      CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_ADDR = 2'b00;
      SDI = 1'b0; SDI_VALID = 1'b0; LUT_IN = '0;
      ACLR = 1'b0;
      model_clear();
      tick();
      for (int i = 0; i < 4; i++) begin
         LUT_IN = (4*NL)'($urandom);
         #1;
         checks++;
         if (CMD_READY !== 1'b1 || DONE !== 1'b0 || ERR !== 1'b0 || SDO_VALID !== 1'b0 ||
             SDO !== 1'b0 || LUT_OUT !== '0) begin
            errors++;
            $display("FAIL reset act=rdy%b done%b err%b sdov%b sdo%b out%b exp=1/0/0/0/0/000",
                     CMD_READY, DONE, ERR, SDO_VALID, SDO, LUT_OUT);
         end
         tick();
      end
      ACLR = 1'b1;
      tick();
   endtask

   task automatic test_load_continuous();
      run_load(2'd2, 16'h8000, 0, "load8000");
      sweep("load8000");
   endtask

   task automatic test_back_to_back();
      run_load(2'd2, 16'h6996, 1, "load6996");
      run_readback(2'd2, "rb6996");
      sweep("rb6996");
   endtask

   task automatic test_reject();
      run_reject(2'b00, 2'd3, "rej_load_addr3");
      run_reject(2'b11, 2'd1, "rej_op11");
      run_reject(2'b01, 2'd3, "rej_read_addr3");
      sweep("reject");
   endtask

   task automatic test_random();
      logic [1:0]  a;
      logic [15:0] m;
      for (int n = 0; n < 6; n++) begin
         a = 2'($urandom_range(0, NL - 1));
         m = 16'($urandom);
         run_load(a, m, 2, "rand_load");
         run_readback(2'($urandom_range(0, NL - 1)), "rand_rb");
      end
      sweep("random");
   endtask

   task automatic test_clear();
      issue(2'b10, 2'd0, "clear");
      LUT_IN = (4*NL)'($urandom);
      #1;
      checks++;
      if (DONE !== 1'b0 || CMD_READY !== 1'b0 || LUT_OUT !== model_out(LUT_IN)) begin
         errors++;
         $display("FAIL clear_cycle1 act=%b/%b/%b exp=0/0/%b", DONE, CMD_READY, LUT_OUT,
                  model_out(LUT_IN));
      end
      tick();
      model_clear();
      LUT_IN = (4*NL)'($urandom);
      #1;
      checks++;
      if (DONE !== 1'b1 || LUT_OUT !== model_out(LUT_IN)) begin
         errors++;
         $display("FAIL clear_done act=%b/%b exp=1/%b", DONE, LUT_OUT, model_out(LUT_IN));
      end
      sweep("clear");
   endtask

   task automatic test_reset_mid_load();
      logic [15:0] m;
      run_load(2'd0, 16'hA5C3, 0, "pre_abort");
      sweep("pre_abort");
      m = 16'($urandom);
      issue(2'b00, 2'd1, "abort");
      for (int k = 0; k < 8; k++) begin
         SDI_VALID = 1'b1;
         SDI       = m[k];
         tick();
      end
      ACLR = 1'b0;
      model_clear();
      LUT_IN = (4*NL)'($urandom);
      #1;
      checks++;
      if (CMD_READY !== 1'b1 || DONE !== 1'b0 || SDO_VALID !== 1'b0 ||
          LUT_OUT !== model_out(LUT_IN)) begin
         errors++;
         $display("FAIL abort_reset act=%b/%b/%b/%b exp=1/0/0/%b", CMD_READY, DONE, SDO_VALID,
                  LUT_OUT, model_out(LUT_IN));
      end
      #2;
      ACLR = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         SDI_VALID = 1'($urandom);
         SDI       = 1'($urandom);
         LUT_IN    = (4*NL)'($urandom);
         #1;
         checks++;
         if (DONE !== 1'b0 || ERR !== 1'b0 || CMD_READY !== 1'b1 ||
             LUT_OUT !== model_out(LUT_IN)) begin
            errors++;
            $display("FAIL abort_idle c=%0d act=%b/%b/%b/%b exp=0/0/1/%b", c, DONE, ERR,
                     CMD_READY, LUT_OUT, model_out(LUT_IN));
         end
      end
      SDI_VALID = 1'b0;
      run_load(2'd1, m, 2, "post_abort");
      run_readback(2'd1, "post_abort_rb");
      sweep("post_abort");
   endtask

   initial begin
      test_reset();
      test_load_continuous();
      test_back_to_back();
      test_reject();
      test_random();
      test_clear();
      test_reset_mid_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
